// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter: producer drives iValid/iData,
// transmitter answers with oReady (FIFO not full).
`timescale 1ns/1ps
interface uart_tx_if;
  logic       iValid;
  logic [7:0] iData;
  logic       oReady;

  modport master (output iValid, output iData, input oReady);
  modport slave  (input iValid, input iData, output oReady);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: bytes queue in a small FIFO and leave as 8N1/8N2 frames,
// LSB first, with optional forced idle gap between frames.
`timescale 1ns/1ps
module uart_tx #(
  parameter int CLKS_PER_BIT = 17,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int GAP_CLKS     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_if.slave                    in_if,
  output logic                        tx,
  output logic                        oBusy,
  output logic [$clog2(FIFO_DEPTH):0] oLevel
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } state_e;

  // ---------------- FIFO ----------------
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          push;
  logic          pop;

  assign in_if.oReady = (count_q != LEVEL_FULL);
  assign push         = in_if.iValid && in_if.oReady;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= in_if.iData;
  end

  // ---------------- Frame FSM ----------------
  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          period_end;

  assign period_end = (clk_cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        gap_cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = fifo_mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        clk_cnt_d = period_end ? '0 : clk_cnt_q + CW'(1);
        if (period_end) state_d = DATA;
      end
      DATA: begin
        clk_cnt_d = period_end ? '0 : clk_cnt_q + CW'(1);
        if (period_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        clk_cnt_d = period_end ? '0 : clk_cnt_q + CW'(1);
        // bit_cnt is reused here to count stop bits
        if (period_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = (GAP_CLKS > 0) ? GAP : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level and busy are registered from the current state, so both lag it by one cycle.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    case (state_q)
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = shift_q[0];
        busy_d = 1'b1;
      end
      STOP:    busy_d = 1'b1;
      default: tx_d   = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign tx     = tx_q;
  assign oBusy  = busy_q;
  assign oLevel = count_q;

endmodule
